// File: rtl/sha256_msg_sched.sv
// SHA-256 message schedule generator: collects 16 message words, then streams W[0..63]
// by sliding a 16-word window one position per accepted output word.
module sha256_msg_sched (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_word,
  output logic        w_valid,
  input  logic        w_ready,
  output logic [31:0] w_word,
  output logic [5:0]  w_idx,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    EMIT = 2'd2
  } state_t;

  state_t      state_r;
  logic [3:0]  count_r;
  logic [5:0]  t_r;
  logic [31:0] win_r [16];
  logic        in_ready_r;
  logic        w_valid_r;
  logic        busy_r;
  logic        done_r;
  logic        in_xfer_s;
  logic        w_xfer_s;
  logic [31:0] next_w_s;

  function automatic logic [31:0] sigma0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] sigma1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b00_0000_0000, x[31:10]};
  endfunction

  // Handshake qualification and the next schedule word entering the window tail.
  always_comb begin
    in_xfer_s = in_valid & in_ready_r;
    w_xfer_s  = w_valid_r & w_ready;
    next_w_s  = sigma1(win_r[14]) + win_r[9] + sigma0(win_r[1]) + win_r[0];
  end

  // Control FSM with registered handshake and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      count_r    <= 4'd0;
      t_r        <= 6'd0;
      in_ready_r <= 1'b1;
      w_valid_r  <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (in_xfer_s) begin
            count_r <= 4'd1;
            busy_r  <= 1'b1;
            state_r <= LOAD;
          end else begin
            count_r <= 4'd0;
          end
        end
        LOAD: begin
          if (in_xfer_s) begin
            // count wraps to zero naturally on the 16th word
            count_r <= count_r + 4'd1;
            if (count_r == 4'd15) begin
              state_r    <= EMIT;
              t_r        <= 6'd0;
              in_ready_r <= 1'b0;
              w_valid_r  <= 1'b1;
            end else begin
              state_r <= LOAD;
            end
          end else begin
            state_r <= LOAD;
          end
        end
        EMIT: begin
          if (w_xfer_s) begin
            if (t_r == 6'd63) begin
              state_r    <= IDLE;
              t_r        <= 6'd0;
              count_r    <= 4'd0;
              in_ready_r <= 1'b1;
              w_valid_r  <= 1'b0;
              busy_r     <= 1'b0;
              done_r     <= 1'b1;
            end else begin
              t_r <= t_r + 6'd1;
            end
          end else begin
            t_r <= t_r;
          end
        end
        default: begin
          state_r    <= IDLE;
          count_r    <= 4'd0;
          t_r        <= 6'd0;
          in_ready_r <= 1'b1;
          w_valid_r  <= 1'b0;
          busy_r     <= 1'b0;
        end
      endcase
    end
  end

  // Message window: loaded by input transfers, slid by output transfers; contents
  // are don't-care after reset, so it carries no reset.
  always_ff @(posedge clk) begin
    if (in_xfer_s) begin
      win_r[count_r] <= in_word;
    end else if (w_xfer_s) begin
      for (int i = 0; i < 15; i++) begin
        win_r[i] <= win_r[i+1];
      end
      win_r[15] <= next_w_s;
    end else begin
      win_r[0] <= win_r[0];
    end
  end

  assign in_ready = in_ready_r;
  assign w_valid  = w_valid_r;
  assign w_word   = win_r[0];
  assign w_idx    = t_r;
  assign busy     = busy_r;
  assign done     = done_r;

endmodule
